cellrv32_clkgen: RTL and testbench

//  Shared clock-prescaler tick generator feeding PWM, UART, SPI, TWI, WDT and other IO consumers.
//  ORs per-consumer enable requests and runs a 12-bit free counter while any request is active.

---
 rtl/cellrv32_package.sv | 21 ++
 rtl/cellrv32_clkgen.sv | 102 ++++++++++
 tb/tb_cellrv32_clkgen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cellrv32_package.sv
// Shared clock-generator constants: tick tap positions, counter width and prescaler select names.
// Consumers use clkgen_div_e to decode their prsc field into an index of clkgen_o.
package cellrv32_package;

    localparam int clkgen_cnt_width_c = 12;

    // Counter bit whose rising edge produces tick k; divider is 2^(tap+1).
    localparam int clkgen_taps_c [0:7] = '{0, 1, 2, 5, 6, 9, 10, 11};

    typedef enum logic [2:0] {
        CLK_DIV2    = 3'd0,
        CLK_DIV4    = 3'd1,
        CLK_DIV8    = 3'd2,
        CLK_DIV64   = 3'd3,
        CLK_DIV128  = 3'd4,
        CLK_DIV1024 = 3'd5,
        CLK_DIV2048 = 3'd6,
        CLK_DIV4096 = 3'd7
    } clkgen_div_e;

endpackage

// File: rtl/cellrv32_clkgen.sv
// Shared prescaler tick generator: 12-bit free counter running while any consumer requests it.
// Define CELLRV32_CLKGEN_HOLDOFF_EN to keep the counter alive HOLDOFF_CYCLES after the last request drops.
module cellrv32_clkgen
    import cellrv32_package::*;
#(
    parameter int NUM_REQ        = 8,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] en_req_i,
    output logic [7:0]         clkgen_o,
    output logic               active_o
);

    typedef enum logic [1:0] {OFF, START, RUN, HOLD} state_t;

    state_t                        state, state_nxt;
    logic [clkgen_cnt_width_c-1:0] cnt, cnt_nxt;
    logic [7:0]                    tick_nxt;
    logic                          req_any;
    logic                          counting;

    if (NUM_REQ < 1 || NUM_REQ > 32) begin : g_bad_num_req
        $error("cellrv32_clkgen: NUM_REQ must be 1..32");
    end
    if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 255) begin : g_bad_holdoff
        $error("cellrv32_clkgen: HOLDOFF_CYCLES must be 1..255");
    end

    assign req_any  = |en_req_i;
    assign cnt_nxt  = cnt + 1'b1;
    assign counting = (state == RUN) || (state == HOLD);

    // A tick is a rising edge of the tapped counter bit; the 4095->0 wrap only has falling edges.
    for (genvar k = 0; k < 8; k++) begin : g_tap
        assign tick_nxt[k] = cnt_nxt[clkgen_taps_c[k]] & ~cnt[clkgen_taps_c[k]];
    end

`ifdef CELLRV32_CLKGEN_HOLDOFF_EN
    logic [7:0] hold_cnt;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            OFF:   if (req_any) state_nxt = START;
            START: state_nxt = req_any ? RUN : OFF;
            RUN: begin
                if (!req_any) begin
`ifdef CELLRV32_CLKGEN_HOLDOFF_EN
                    state_nxt = HOLD;
`else
                    state_nxt = OFF;
`endif
                end
            end
`ifdef CELLRV32_CLKGEN_HOLDOFF_EN
            HOLD: begin
                if (req_any)            state_nxt = RUN;
                else if (hold_cnt == '0) state_nxt = OFF;
            end
`endif
            default: state_nxt = OFF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= OFF;
            cnt      <= '0;
            clkgen_o <= '0;
            active_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            active_o <= (state_nxt != OFF);
            // Leaving for OFF clears at once so no partial strobe escapes.
            if (counting && (state_nxt != OFF)) begin
                cnt      <= cnt_nxt;
                clkgen_o <= tick_nxt;
            end else begin
                cnt      <= '0;
                clkgen_o <= '0;
            end
        end
    end

`ifdef CELLRV32_CLKGEN_HOLDOFF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_cnt <= '0;
        end else if ((state == RUN) && (state_nxt == HOLD)) begin
            hold_cnt <= 8'(HOLDOFF_CYCLES - 1);
        end else if ((state == HOLD) && (state_nxt == HOLD)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cellrv32_clkgen.sv
// Self-checking bench for cellrv32_clkgen: vector table, multi-cycle corner sequences and random requests
// against a counting reference model (tick k fires when edges-since-RUN n satisfies n mod 2^(t+1) == 2^t).
module tb_cellrv32_clkgen;

    localparam int NUM_REQ = 8;
    localparam int HOLD_C  = 16;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [NUM_REQ-1:0] en_req_i;
    logic [7:0]         clkgen_o;
    logic               active_o;

    cellrv32_clkgen #(
        .NUM_REQ        (NUM_REQ),
        .HOLDOFF_CYCLES (HOLD_C)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_req_i (en_req_i),
        .clkgen_o (clkgen_o),
        .active_o (active_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // Reference model
    typedef enum int {M_OFF, M_START, M_RUN, M_HOLD} mode_t;
    int    taps [8] = '{0, 1, 2, 5, 6, 9, 10, 11};
    mode_t m_mode = M_OFF;
    longint m_n   = 0;
    int    m_hold = 0;
    logic [7:0] m_clk = '0;
    logic  m_act  = 1'b0;

    function automatic logic [7:0] exp_ticks(input longint n);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            longint p;
            p = longint'(1) << taps[k];
            if ((n % (2 * p)) == p) r[k] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_edge(input logic rst, input logic req_any);
        bit go_off;
        if (rst) begin
            m_mode = M_OFF; m_n = 0; m_clk = '0; m_act = 1'b0; m_hold = 0;
        end else if (m_mode == M_OFF) begin
            if (req_any) m_mode = M_START;
            m_clk = '0; m_act = req_any;
        end else if (m_mode == M_START) begin
            m_mode = req_any ? M_RUN : M_OFF;
            m_n = 0; m_clk = '0; m_act = req_any;
        end else begin
            go_off = 1'b0;
            if (req_any) begin
                m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
`ifdef CELLRV32_CLKGEN_HOLDOFF_EN
                m_mode = M_HOLD; m_hold = HOLD_C - 1;
`else
                go_off = 1'b1;
`endif
            end else if (m_hold == 0) begin
                go_off = 1'b1;
            end else begin
                m_hold--;
            end
            if (go_off) begin
                m_mode = M_OFF; m_n = 0; m_clk = '0; m_act = 1'b0;
            end else begin
                m_n++; m_clk = exp_ticks(m_n); m_act = 1'b1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [7:0] req, input bit cmp);
        rst_i    = rst;
        en_req_i = req;
        @(posedge clk_i);
        #1;
        model_edge(rst, |req);
        if (cmp) begin
            check("model clkgen_o", clkgen_o, m_clk);
            check("model active_o", active_o, m_act);
        end
    endtask

    typedef struct packed {
        logic       rst;
        logic [7:0] req;
        logic [7:0] exp_clk;
        logic       exp_act;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int cnt [8];
        int exp_cnt [8];
        logic [7:0] prev;
        logic [7:0] dbl;
        logic [7:0] rq;
        bit   fell;
        int   after;

        rst_i    = 1'b1;
        en_req_i = '0;

        // Reset with all requests high, then release with only en_req_i[3].
        repeat (5) vecs.push_back('{1'b1, 8'hFF, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'h08, 8'h00, 1'b1});   // OFF -> START
        vecs.push_back('{1'b0, 8'h08, 8'h00, 1'b1});   // START -> RUN
        vecs.push_back('{1'b0, 8'h08, 8'h01, 1'b1});   // n=1
        vecs.push_back('{1'b0, 8'h08, 8'h02, 1'b1});   // n=2
        vecs.push_back('{1'b0, 8'h08, 8'h01, 1'b1});   // n=3
        vecs.push_back('{1'b0, 8'h08, 8'h04, 1'b1});   // n=4
        vecs.push_back('{1'b0, 8'h08, 8'h01, 1'b1});
        vecs.push_back('{1'b0, 8'h08, 8'h02, 1'b1});
        vecs.push_back('{1'b0, 8'h08, 8'h01, 1'b1});
        vecs.push_back('{1'b0, 8'h08, 8'h00, 1'b1});   // n=8: bit3 is not a tap

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req, 1'b0);
            check($sformatf("vec%0d clkgen_o", i), clkgen_o, vecs[i].exp_clk);
            check($sformatf("vec%0d active_o", i), active_o, vecs[i].exp_act);
        end

        // Long run over two counter wraps: pulse counts and pulse width.
        step(1'b1, 8'h00, 1'b1);
        step(1'b0, 8'h01, 1'b1);
        step(1'b0, 8'h01, 1'b1);
        exp_cnt = '{4096, 2048, 1024, 128, 64, 8, 4, 2};
        cnt  = '{default: 0};
        prev = '0;
        dbl  = '0;
        for (int c = 0; c < 8192; c++) begin
            step(1'b0, 8'h80, 1'b0);
            for (int k = 0; k < 8; k++) if (clkgen_o[k]) cnt[k]++;
            dbl  = dbl | (clkgen_o & prev);
            prev = clkgen_o;
        end
        for (int k = 0; k < 8; k++) check($sformatf("pulse count [%0d]", k), cnt[k], exp_cnt[k]);
        check("pulse width", dbl, 8'h00);

`ifndef CELLRV32_CLKGEN_HOLDOFF_EN
        // Drop requests mid-RUN at cnt=37, then re-raise.
        step(1'b1, 8'h00, 1'b1);
        step(1'b0, 8'h08, 1'b1);
        step(1'b0, 8'h08, 1'b1);
        repeat (37) step(1'b0, 8'h08, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("drop active_o", active_o, 1'b0);
        check("drop clkgen_o", clkgen_o, 8'h00);
        step(1'b0, 8'h08, 1'b1);
        check("reraise START active_o", active_o, 1'b1);
        check("reraise START clkgen_o", clkgen_o, 8'h00);
        step(1'b0, 8'h08, 1'b1);
        check("reraise RUN entry clkgen_o", clkgen_o, 8'h00);
        step(1'b0, 8'h08, 1'b1);
        check("reraise phase0 clkgen_o", clkgen_o, 8'h01);
        step(1'b0, 8'h08, 1'b1);
        check("reraise phase1 clkgen_o", clkgen_o, 8'h02);
`else
        // Short gap keeps phase; long gap turns off exactly HOLD_C cycles after HOLD entry.
        step(1'b1, 8'h00, 1'b1);
        step(1'b0, 8'h01, 1'b1);
        step(1'b0, 8'h01, 1'b1);
        repeat (20) step(1'b0, 8'h01, 1'b1);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 8'h00, 1'b1);
            check("hold active_o", active_o, 1'b1);
        end
        repeat (10) step(1'b0, 8'h01, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        fell  = 1'b0;
        after = 0;
        for (int c = 1; c <= 40 && !fell; c++) begin
            step(1'b0, 8'h00, 1'b1);
            if (!active_o) begin
                fell  = 1'b1;
                after = c;
            end
        end
        check("hold expiry seen", fell, 1'b1);
        check("hold expiry cycles", after, HOLD_C);
        // Reset pulse mid-HOLD.
        step(1'b0, 8'h01, 1'b1);
        step(1'b0, 8'h01, 1'b1);
        repeat (9) step(1'b0, 8'h01, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        check("rst in HOLD active_o", active_o, 1'b0);
        check("rst in HOLD clkgen_o", clkgen_o, 8'h00);
`endif

        // Reset pulse mid-RUN with requests held high.
        step(1'b0, 8'hFF, 1'b1);
        step(1'b0, 8'hFF, 1'b1);
        repeat (15) step(1'b0, 8'hFF, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        check("rst in RUN active_o", active_o, 1'b0);
        check("rst in RUN clkgen_o", clkgen_o, 8'h00);
        step(1'b0, 8'hFF, 1'b1);
        check("after rst START active_o", active_o, 1'b1);
        step(1'b0, 8'hFF, 1'b1);
        check("after rst RUN entry clkgen_o", clkgen_o, 8'h00);
        step(1'b0, 8'hFF, 1'b1);
        check("after rst phase0 clkgen_o", clkgen_o, 8'h01);

        // Random requests with occasional reset, checked every cycle against the model.
        rq = 8'h00;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0)
                rq = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            step(($urandom_range(0, 399) == 0), rq, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
